sr_latch_ctrl: RTL and testbench

Synchronous sequencer and arbiter that drives an external NAND-based SR latch through its active-low s_n/r_n inputs.
- Two requesters share the latch: one sets it, one clears it.
- Grants one request at a time and produces a fixed-width set or reset pulse, then a settle window.
- By construction, s_n and r_n are never both low (the NAND forbidden state).
- Tracks the expected latch value and signals completion per request.

---
 rtl/sr_latch_ctrl_pkg.sv | 20 ++
 rtl/sr_latch_ctrl_sync2.sv | 21 ++
 rtl/sr_latch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_ctrl_pkg.sv
// Shared encodings and reset constants for the SR latch sequencer.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    VERIFY = 2'd3
  } state_t;

  typedef enum logic {
    OP_CLR = 1'b0,
    OP_SET = 1'b1
  } op_t;

  // Both latch inputs released (high) is the only safe idle drive.
  localparam logic S_N_RST = 1'b1;
  localparam logic R_N_RST = 1'b1;

endpackage

// File: rtl/sr_latch_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous latch Q feedback.
module sr_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Arbiter/sequencer driving an external NAND SR latch via s_n/r_n.
// Optional readback check of the latch enabled by defining SR_VERIFY_EN.
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned PULSE_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_in,
  output logic s_n,
  output logic r_n,
  output logic set_ack,
  output logic clr_ack,
  output logic busy,
  output logic done,
  output logic q_exp,
  output logic err
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  op_t              op, op_nxt;
  op_t              last_grant, last_grant_nxt;
  logic             s_n_nxt, r_n_nxt, set_ack_nxt, clr_ack_nxt;
  logic             busy_nxt, done_nxt, q_exp_nxt, err_nxt;
  logic             grant;
  op_t              grant_op;

`ifdef SR_VERIFY_EN
  logic q_sync;

  sr_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (q_in),
    .q   (q_sync)
  );
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
`endif

  // Round-robin on contention; a lone request always wins.
  always_comb begin
    grant = set_req | clr_req;
    if (set_req && clr_req) begin
      grant_op = (last_grant == OP_CLR) ? OP_SET : OP_CLR;
    end else begin
      grant_op = set_req ? OP_SET : OP_CLR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op         <= OP_CLR;
      last_grant <= OP_CLR;
      s_n        <= S_N_RST;
      r_n        <= R_N_RST;
      set_ack    <= 1'b0;
      clr_ack    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      q_exp      <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      op         <= op_nxt;
      last_grant <= last_grant_nxt;
      s_n        <= s_n_nxt;
      r_n        <= r_n_nxt;
      set_ack    <= set_ack_nxt;
      clr_ack    <= clr_ack_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      q_exp      <= q_exp_nxt;
      err        <= err_nxt;
    end
  end

  // Only one of s_n/r_n can ever be driven low, keyed on op.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    op_nxt         = op;
    last_grant_nxt = last_grant;
    s_n_nxt        = S_N_RST;
    r_n_nxt        = R_N_RST;
    set_ack_nxt    = 1'b0;
    clr_ack_nxt    = 1'b0;
    busy_nxt       = 1'b0;
    done_nxt       = 1'b0;
    q_exp_nxt      = q_exp;
`ifdef SR_VERIFY_EN
    err_nxt        = err;
`else
    err_nxt        = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt      = PULSE;
          cnt_nxt        = CNT_W'(PULSE_CYC - 1);
          op_nxt         = grant_op;
          last_grant_nxt = grant_op;
          set_ack_nxt    = (grant_op == OP_SET);
          clr_ack_nxt    = (grant_op == OP_CLR);
          busy_nxt       = 1'b1;
          s_n_nxt        = (grant_op != OP_SET);
          r_n_nxt        = (grant_op != OP_CLR);
        end
      end

      PULSE: begin
        busy_nxt = 1'b1;
        if (cnt == '0) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          s_n_nxt = (op != OP_SET);
          r_n_nxt = (op != OP_CLR);
        end
      end

      SETTLE: begin
        busy_nxt = 1'b1;
        if (cnt == '0) begin
`ifdef SR_VERIFY_EN
          state_nxt = VERIFY;
`else
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          q_exp_nxt = op;
`endif
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

`ifdef SR_VERIFY_EN
      VERIFY: begin
        busy_nxt  = 1'b1;
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        q_exp_nxt = op;
        if (q_sync != op) begin
          err_nxt = 1'b1;
        end
      end
`endif

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Self-checking bench for sr_latch_ctrl: table vectors with a scoreboard queue
// plus hand-written reset, contention and readback-mismatch sequences.
module tb_sr_latch_ctrl;

  localparam int P0 = 4;
  localparam int S0 = 2;
  localparam int P1 = 1;
  localparam int S1 = 1;
`ifdef SR_VERIFY_EN
  localparam int V = 1;
`else
  localparam int V = 0;
`endif
  localparam int DC0 = P0 + S0 + 1 + V;
  localparam int N   = DC0 + 2;

  typedef struct packed {
    logic s_n;
    logic r_n;
    logic set_ack;
    logic clr_ack;
    logic busy;
    logic done;
    logic q_exp;
    logic err;
  } out_t;

  typedef struct {
    logic set_req;
    logic clr_req;
    out_t e0;
    out_t e1;
  } vec_t;

  localparam out_t RST_O = out_t'(8'b1100_0000);

  logic clk = 1'b0;
  logic rst, set_req, clr_req, force_lo;
  logic lq0, lq1, q_in0, q_in1;
  logic s_n0, r_n0, set_ack0, clr_ack0, busy0, done0, q_exp0, err0;
  logic s_n1, r_n1, set_ack1, clr_ack1, busy1, done1, q_exp1, err1;
  out_t o0, o1;
  int   n_tot = 0;
  int   n_bad = 0;
  vec_t tbl_clr[N];
  vec_t tbl_set[N];
  out_t sb0[$];
  out_t sb1[$];

  always #5 clk = ~clk;

  sr_latch_ctrl #(.PULSE_CYC(P0), .SETTLE_CYC(S0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_in(q_in0),
    .s_n(s_n0), .r_n(r_n0), .set_ack(set_ack0), .clr_ack(clr_ack0),
    .busy(busy0), .done(done0), .q_exp(q_exp0), .err(err0)
  );

  sr_latch_ctrl #(.PULSE_CYC(P1), .SETTLE_CYC(S1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_in(q_in1),
    .s_n(s_n1), .r_n(r_n1), .set_ack(set_ack1), .clr_ack(clr_ack1),
    .busy(busy1), .done(done1), .q_exp(q_exp1), .err(err1)
  );

  assign o0 = {s_n0, r_n0, set_ack0, clr_ack0, busy0, done0, q_exp0, err0};
  assign o1 = {s_n1, r_n1, set_ack1, clr_ack1, busy1, done1, q_exp1, err1};

  // Behavioural NAND latches; force_lo makes dut's readback disagree.
  initial begin
    lq0 = 1'b0;
    lq1 = 1'b0;
  end
  always @(s_n0 or r_n0) begin
    if (!s_n0) lq0 = 1'b1;
    else if (!r_n0) lq0 = 1'b0;
  end
  always @(s_n1 or r_n1) begin
    if (!s_n1) lq1 = 1'b1;
    else if (!r_n1) lq1 = 1'b0;
  end
  assign q_in0 = force_lo ? 1'b0 : lq0;
  assign q_in1 = lq1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected outputs c cycles after a request was presented in cycle 0.
  function automatic out_t exp_at(int c, logic is_set, int p, int s, logic q_before);
    out_t o;
    int   dc;
    dc        = p + s + 1 + V;
    o.s_n     = !(is_set && c >= 1 && c <= p);
    o.r_n     = !(!is_set && c >= 1 && c <= p);
    o.set_ack = is_set && (c == 1);
    o.clr_ack = !is_set && (c == 1);
    o.busy    = (c >= 1) && (c <= dc);
    o.done    = (c == dc);
    o.q_exp   = (c >= dc) ? is_set : q_before;
    o.err     = 1'b0;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(string name, out_t act, out_t exp_v);
    n_tot++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (s_n r_n set_ack clr_ack busy done q_exp err) t=%0t",
               name, act, exp_v, $time);
    end
  endtask

  task automatic cmp_int(string name, int act, int exp_v);
    n_tot++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check_inv();
    n_tot++;
    if (!(s_n0 | r_n0) || !(s_n1 | r_n1)) begin
      n_bad++;
      $display("FAIL nand_forbidden: s_n0=%b r_n0=%b s_n1=%b r_n1=%b t=%0t",
               s_n0, r_n0, s_n1, r_n1, $time);
    end
  endtask

  task automatic run_table(input logic use_set);
    vec_t v;
    for (int i = 0; i < N; i++) begin
      v = use_set ? tbl_set[i] : tbl_clr[i];
      set_req = v.set_req;
      clr_req = v.clr_req;
      sb0.push_back(v.e0);
      sb1.push_back(v.e1);
      @(negedge clk);
      check_inv();
      cmp(use_set ? "set_p4s2" : "clr_p4s2", o0, sb0.pop_front());
      cmp(use_set ? "set_p1s1" : "clr_p1s1", o1, sb1.pop_front());
      tick();
    end
  endtask

  initial begin
    int   ack_cyc[3];
    logic ack_set[3];
    int   na;
    int   waited;

    for (int c = 0; c < N; c++) begin
      tbl_clr[c].set_req = 1'b0;
      tbl_clr[c].clr_req = (c == 0);
      tbl_clr[c].e0      = exp_at(c, 1'b0, P0, S0, 1'b0);
      tbl_clr[c].e1      = exp_at(c, 1'b0, P1, S1, 1'b0);
      tbl_set[c].set_req = (c == 0);
      tbl_set[c].clr_req = 1'b0;
      tbl_set[c].e0      = exp_at(c, 1'b1, P0, S0, 1'b0);
      tbl_set[c].e1      = exp_at(c, 1'b1, P1, S1, 1'b0);
    end

    rst      = 1'b1;
    set_req  = 1'b0;
    clr_req  = 1'b0;
    force_lo = 1'b0;
    #2;
    cmp("reset_p4s2", o0, RST_O);
    cmp("reset_p1s1", o1, RST_O);
    tick();
    tick();
    rst = 1'b0;

    // Redundant clear first (q_exp stays 0), then a set.
    run_table(1'b0);
    run_table(1'b1);

    // Reset in the middle of a set pulse.
    set_req = 1'b1;
    tick();
    set_req = 1'b0;
    tick();
    @(negedge clk);
    cmp_int("mid_pulse_s_n", int'(s_n0), 0);
    #2 rst = 1'b1;
    #1;
    cmp("rst_async_p4s2", o0, RST_O);
    cmp("rst_async_p1s1", o1, RST_O);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_inv();
      cmp("post_rst_idle", o0, RST_O);
      tick();
    end

    // Contention from reset: SET first, then alternate back-to-back.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req = 1'b1;
    clr_req = 1'b1;
    na = 0;
    for (int c = 1; c <= 60 && na < 3; c++) begin
      tick();
      @(negedge clk);
      check_inv();
      if (set_ack0 || clr_ack0) begin
        ack_cyc[na] = c;
        ack_set[na] = set_ack0;
        na++;
      end
    end
    cmp_int("contend_ack_count", na, 3);
    if (na == 3) begin
      for (int i = 0; i < 3; i++) begin
        cmp_int("contend_op_is_set", int'(ack_set[i]), (i % 2 == 0) ? 1 : 0);
        cmp_int("contend_ack_cycle", ack_cyc[i], 1 + i * DC0);
      end
    end
    set_req = 1'b0;
    clr_req = 1'b0;
    waited = 0;
    while ((busy0 || busy1) && waited < 30) begin
      tick();
      @(negedge clk);
      check_inv();
      waited++;
    end
    cmp_int("contend_drain", int'(busy0 | busy1), 0);
    cmp_int("contend_q_exp", int'(q_exp0), 1);
    tick();

    // Readback disagrees with a set: err only exists with the check enabled.
    force_lo = 1'b1;
    set_req  = 1'b1;
    tick();
    set_req = 1'b0;
    repeat (DC0 - 1) tick();
    @(negedge clk);
    cmp_int("force_done", int'(done0), 1);
    cmp_int("force_err", int'(err0), V);
    cmp_int("force_err_other", int'(err1), 0);
    repeat (3) tick();
    @(negedge clk);
    cmp_int("force_err_sticky", int'(err0), V);
    cmp_int("force_idle", int'(busy0), 0);
    force_lo = 1'b0;
    #1 rst = 1'b1;
    #1;
    cmp_int("err_cleared_by_rst", int'(err0), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
